// File: rtl/corelet_ctrl.sv
// Corelet sequencer: streams weights, then activations, into L0 per kernel position and drains the OFIFO into the SFP.
// Defining CORELET_CTRL_PERF_EN adds a 16-bit saturating stall counter output (stall_cnt).
module corelet_ctrl #(
  parameter int col      = 8,
  parameter int row      = 8,
  parameter int len_kij  = 9,
  parameter int len_nij  = 36,
  parameter int l0_depth = 64,
  parameter int addr_bw  = 11,
  parameter int w_base   = 0,
  parameter int a_base   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ofifo_valid,
  input  logic               l0_full,
  output logic               mem_rd,
  output logic [addr_bw-1:0] mem_addr,
  output logic               l0_wr,
  output logic               l0_rd,
  output logic [1:0]         inst_w,
  output logic               ofifo_rd,
  output logic               acc,
  output logic               busy,
  output logic               done,
`ifdef CORELET_CTRL_PERF_EN
  output logic               err,
  output logic [15:0]        stall_cnt
`else
  output logic               err
`endif
);

  localparam int KW   = $clog2(len_kij + 1);
  localparam int CMAX = (col > len_nij) ? ((col > row) ? col : row)
                                        : ((len_nij > row) ? len_nij : row);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int OW   = $clog2(l0_depth + 2);

  localparam logic [CW-1:0] COL_N    = CW'(col);
  localparam logic [CW-1:0] COL_LAST = CW'(col - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(row - 1);
  localparam logic [CW-1:0] NIJ_N    = CW'(len_nij);
  localparam logic [CW-1:0] NIJ_LAST = CW'(len_nij - 1);
  localparam logic [KW-1:0] KIJ_LAST = KW'(len_kij - 1);
  localparam logic [OW-1:0] DEPTH    = OW'(l0_depth);

  typedef enum logic [2:0] {
    IDLE, WFILL, WLOAD, WFLUSH, EXEC, DRAIN, NEXT, FIN
  } state_e;

  state_e               state_q;
  logic [KW-1:0]        kij_q;
  logic [CW-1:0]        rd_cnt_q;
  logic [CW-1:0]        wr_cnt_q;
  logic [CW-1:0]        pop_cnt_q;
  logic [OW-1:0]        occ_q;
  logic                 mem_rd_q;
  logic [addr_bw-1:0]   mem_addr_q;
  logic                 l0_wr_q;
  logic                 l0_rd_q;
  logic [1:0]           inst_w_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  logic [OW-1:0]        occ_d;
  logic                 credit_ok;
  logic                 rd_want;
  logic                 rd_go;
  logic [addr_bw-1:0]   rd_addr;
  logic                 pop_want;
  logic                 pop_go;
  logic                 ofifo_pop;

  // Occupancy as it will stand next cycle; a read issued now lands one cycle
  // after the one already in flight, so both count against the credit.
  always_comb begin
    occ_d     = occ_q + OW'(l0_wr_q) - OW'(l0_rd_q);
    credit_ok = (occ_d + OW'(mem_rd_q)) < DEPTH;
    rd_want   = 1'b0;
    rd_addr   = '0;
    pop_want  = 1'b0;
    case (state_q)
      WFILL: begin
        rd_want = rd_cnt_q < COL_N;
        rd_addr = addr_bw'(w_base) + addr_bw'(kij_q) * addr_bw'(col) + addr_bw'(rd_cnt_q);
      end
      WLOAD: pop_want = pop_cnt_q < COL_N;
      EXEC: begin
        rd_want  = rd_cnt_q < NIJ_N;
        rd_addr  = addr_bw'(a_base) + addr_bw'(rd_cnt_q);
        pop_want = pop_cnt_q < NIJ_N;
      end
      default: ;
    endcase
    rd_go     = rd_want && credit_ok;
    pop_go    = pop_want && (occ_d != '0);
    ofifo_pop = (state_q == DRAIN) && ofifo_valid && (pop_cnt_q < NIJ_N);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      kij_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      pop_cnt_q  <= '0;
      occ_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      l0_wr_q    <= 1'b0;
      l0_rd_q    <= 1'b0;
      inst_w_q   <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      l0_wr_q  <= mem_rd_q;
      l0_rd_q  <= 1'b0;
      inst_w_q <= 2'b00;
      done_q   <= 1'b0;
      occ_q    <= occ_d;
      err_q    <= err_q | (l0_full & l0_wr_q);
      if (l0_wr_q) wr_cnt_q <= wr_cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= WFILL;
            busy_q    <= 1'b1;
            kij_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            pop_cnt_q <= '0;
          end
        end
        WFILL: begin
          if (rd_go) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= rd_addr;
            rd_cnt_q   <= rd_cnt_q + 1'b1;
          end
          if (l0_wr_q && (wr_cnt_q == COL_LAST)) begin
            state_q   <= WLOAD;
            pop_cnt_q <= '0;
          end
        end
        WLOAD: begin
          if (pop_go) begin
            l0_rd_q   <= 1'b1;
            inst_w_q  <= 2'b01;
            pop_cnt_q <= pop_cnt_q + 1'b1;
          end
          if (pop_cnt_q == COL_N) begin
            state_q   <= WFLUSH;
            pop_cnt_q <= '0;
          end
        end
        WFLUSH: begin
          pop_cnt_q <= pop_cnt_q + 1'b1;
          if (pop_cnt_q == ROW_LAST) begin
            state_q   <= EXEC;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            pop_cnt_q <= '0;
          end
        end
        EXEC: begin
          if (rd_go) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= rd_addr;
            rd_cnt_q   <= rd_cnt_q + 1'b1;
          end
          if (pop_go) begin
            l0_rd_q   <= 1'b1;
            inst_w_q  <= 2'b10;
            pop_cnt_q <= pop_cnt_q + 1'b1;
          end
          if (pop_cnt_q == NIJ_N) begin
            state_q   <= DRAIN;
            pop_cnt_q <= '0;
          end
        end
        DRAIN: begin
          if (ofifo_pop) begin
            pop_cnt_q <= pop_cnt_q + 1'b1;
            if (pop_cnt_q == NIJ_LAST) state_q <= NEXT;
          end
        end
        NEXT: begin
          if (kij_q == KIJ_LAST) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            kij_q     <= kij_q + 1'b1;
            state_q   <= WFILL;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            pop_cnt_q <= '0;
          end
        end
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // OFIFO pop must follow ofifo_valid in the same cycle, so it stays combinational.
  assign ofifo_rd = ofifo_pop;
  assign acc      = ofifo_pop && (kij_q != '0);
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign l0_wr    = l0_wr_q;
  assign l0_rd    = l0_rd_q;
  assign inst_w   = inst_w_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

`ifdef CORELET_CTRL_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if (((rd_want && !credit_ok) || ((state_q == DRAIN) && !ofifo_valid))
                 && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// Scoreboard bench for corelet_ctrl: expected SRAM addresses, instruction pops and acc flags are queued per run.
module tb_corelet_ctrl;

  localparam int COL   = 4;
  localparam int ROW   = 4;
  localparam int KIJ   = 3;
  localparam int NIJ   = 12;
  localparam int DEPTH = 4;
  localparam int ABW   = 11;
  localparam int WB    = 0;
  localparam int AB    = 1024;

  logic           clk;
  logic           reset;
  logic           start;
  logic           ofifo_valid;
  logic           l0_full;
  logic           mem_rd;
  logic [ABW-1:0] mem_addr;
  logic           l0_wr;
  logic           l0_rd;
  logic [1:0]     inst_w;
  logic           ofifo_rd;
  logic           acc;
  logic           busy;
  logic           done;
  logic           err;
`ifdef CORELET_CTRL_PERF_EN
  logic [15:0]    stall_cnt;
`endif

  corelet_ctrl #(
    .col(COL), .row(ROW), .len_kij(KIJ), .len_nij(NIJ), .l0_depth(DEPTH),
    .addr_bw(ABW), .w_base(WB), .a_base(AB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .l0_full(l0_full), .mem_rd(mem_rd), .mem_addr(mem_addr), .l0_wr(l0_wr),
    .l0_rd(l0_rd), .inst_w(inst_w), .ofifo_rd(ofifo_rd), .acc(acc),
    .busy(busy), .done(done),
`ifdef CORELET_CTRL_PERF_EN
    .err(err), .stall_cnt(stall_cnt)
`else
    .err(err)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  int addr_q[$];
  int inst_q[$];
  int acc_q[$];

  int cyc = 0;
  int done_cnt = 0;
  int acc0_cnt, acc1_cnt, wload_cnt, exec_cnt, ofifo_cnt;
  int occ, max_occ, wr_bad, inst_bad, rd_bad;
  int last_w, min_gap;
  bit w_pending;
  logic prev_mem_rd;
  bit vld_toggle = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    acc0_cnt = 0; acc1_cnt = 0; wload_cnt = 0; exec_cnt = 0; ofifo_cnt = 0;
    max_occ = 0; wr_bad = 0; inst_bad = 0; rd_bad = 0;
    min_gap = 1000; w_pending = 1'b0;
  endtask

  task automatic push_run();
    for (int k = 0; k < KIJ; k++) begin
      for (int i = 0; i < COL; i++) begin
        addr_q.push_back(WB + k * COL + i);
        inst_q.push_back(1);
      end
      for (int n = 0; n < NIJ; n++) begin
        addr_q.push_back(AB + n);
        inst_q.push_back(2);
        acc_q.push_back((k != 0) ? 1 : 0);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 3000 && done_cnt == base; i++) step();
    check_eq("done_seen", done_cnt, base + 1);
    repeat (3) step();
    check_eq("done_single", done_cnt, base + 1);
  endtask

  task automatic post_checks(input logic exp_err);
    check_eq("busy_after", busy, 1'b0);
    check_eq("done_low", done, 1'b0);
    check_eq("err_after", err, exp_err);
    check_eq("addr_left", addr_q.size(), 0);
    check_eq("inst_left", inst_q.size(), 0);
    check_eq("acc_left", acc_q.size(), 0);
    check_eq("wload_cnt", wload_cnt, KIJ * COL);
    check_eq("exec_cnt", exec_cnt, KIJ * NIJ);
    check_eq("ofifo_cnt", ofifo_cnt, KIJ * NIJ);
    check_eq("acc0_cnt", acc0_cnt, NIJ);
    check_eq("acc1_cnt", acc1_cnt, (KIJ - 1) * NIJ);
    check_eq("occ_bound", max_occ <= DEPTH, 1'b1);
    check_eq("wr_follows_rd", wr_bad, 0);
    check_eq("inst_idle_zero", inst_bad, 0);
    check_eq("ofifo_rd_valid", rd_bad, 0);
    check_eq("flush_gap", min_gap > ROW, 1'b1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ofifo_valid = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ofifo_valid = vld_toggle ? ~ofifo_valid : 1'b1;
    end
  end

  // Monitor: compares every SRAM read, L0 pop and OFIFO pop against the queues.
  initial begin
    int e;
    prev_mem_rd = 1'b0;
    occ = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_mem_rd = 1'b0;
        occ = 0;
      end else begin
        if (l0_wr !== prev_mem_rd) wr_bad++;
        prev_mem_rd = mem_rd;
        if (mem_rd) begin
          if (addr_q.size() != 0) e = addr_q.pop_front();
          else e = -1;
          check_eq("mem_addr", 32'(mem_addr), e);
        end
        if (l0_rd) begin
          if (inst_q.size() != 0) e = inst_q.pop_front();
          else e = 3;
          check_eq("inst_w", 32'(inst_w), e);
          if (inst_w == 2'b01) begin
            wload_cnt++;
            last_w = cyc;
            w_pending = 1'b1;
          end else if (inst_w == 2'b10) begin
            exec_cnt++;
            if (w_pending && (cyc - last_w) < min_gap) min_gap = cyc - last_w;
            w_pending = 1'b0;
          end
        end else if (inst_w != 2'b00) begin
          inst_bad++;
        end
        occ = occ + int'(l0_wr) - int'(l0_rd);
        if (occ > max_occ) max_occ = occ;
        if (ofifo_rd) begin
          if (!ofifo_valid) rd_bad++;
          if (acc_q.size() != 0) e = acc_q.pop_front();
          else e = 2;
          check_eq("acc", 32'(acc), e);
          ofifo_cnt++;
          if (acc) acc1_cnt++;
          else acc0_cnt++;
        end
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    l0_full = 1'b0;
    clear_stats();
    repeat (2) step();
    check_eq("rst_mem_rd", mem_rd, 1'b0);
    check_eq("rst_mem_addr", 32'(mem_addr), 0);
    check_eq("rst_l0_wr", l0_wr, 1'b0);
    check_eq("rst_l0_rd", l0_rd, 1'b0);
    check_eq("rst_inst_w", 32'(inst_w), 0);
    check_eq("rst_ofifo_rd", ofifo_rd, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    reset = 1'b0;
    step();

    // Run A: ofifo_valid tied high, a stray start mid-run must be ignored.
    clear_stats();
    push_run();
    pulse_start();
    check_eq("busy_on_start", busy, 1'b1);
    repeat (15) step();
    pulse_start();
    wait_done(0);
    post_checks(1'b0);

    // Run B: ofifo_valid toggling, plus an l0_full hit during the first weight write.
    vld_toggle = 1'b1;
    clear_stats();
    push_run();
    pulse_start();
    for (int i = 0; i < 50 && !l0_wr; i++) step();
    l0_full = 1'b1;
    step();
    l0_full = 1'b0;
    check_eq("err_set", err, 1'b1);
    wait_done(1);
    post_checks(1'b1);
`ifdef CORELET_CTRL_PERF_EN
    check_eq("stall_drain_lo", stall_cnt >= 16'(KIJ * (NIJ - 1)), 1'b1);
`endif
    vld_toggle = 1'b0;

    // Run C: reset while executing aborts without a done pulse.
    push_run();
    pulse_start();
    for (int i = 0; i < 500 && inst_w != 2'b10; i++) step();
    check_eq("exec_reached", 32'(inst_w), 2);
    reset = 1'b1;
    #1;
    check_eq("abort_mem_rd", mem_rd, 1'b0);
    check_eq("abort_l0_wr", l0_wr, 1'b0);
    check_eq("abort_l0_rd", l0_rd, 1'b0);
    check_eq("abort_inst_w", 32'(inst_w), 0);
    check_eq("abort_ofifo_rd", ofifo_rd, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_err", err, 1'b0);
    addr_q.delete();
    inst_q.delete();
    acc_q.delete();
    step();
    reset = 1'b0;
    repeat (30) step();
    check_eq("abort_no_done", done_cnt, 2);
    check_eq("abort_idle", busy, 1'b0);

    // Run D: normal run after abort; a start in the FIN cycle is ignored.
    clear_stats();
    push_run();
    pulse_start();
    for (int i = 0; i < 3000 && ofifo_cnt < KIJ * NIJ; i++) step();
    step();
    step();
    check_eq("fin_done", done, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    check_eq("fin_start_ignored", busy, 1'b0);
    check_eq("run_d_done", done_cnt, 3);
    post_checks(1'b0);
`ifdef CORELET_CTRL_PERF_EN
    check_eq("stall_cleared", stall_cnt < 16'(KIJ * (NIJ - 1)), 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
